// File: rtl/seg_disp_pkg.sv
// Shared constants and types for the 7-segment display bus capture monitor.
package seg_disp_pkg;

    localparam int SEG_W   = 7;
    localparam int NUM_DIG = 6;

    // Segment patterns for hex digits 0..F, bits a..g (index 15 first).
    localparam logic [15:0][SEG_W-1:0] HEX_TBL = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HELD
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Maps a 7-segment pattern back to its hex digit; unknown patterns flag err.
module seg7_decode
    import seg_disp_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic [3:0]       o_digit,
    output logic             o_err
);

    always_comb begin
        o_digit = 4'd0;
        o_err   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == HEX_TBL[i]) begin
                o_digit = 4'(i);
                o_err   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_disp_capture.sv
// Debounces the scanned 7-segment bus, decodes each digit and assembles
// 6-digit frames delivered over a valid/ready handshake.
module seg_disp_capture
    import seg_disp_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_DIG-1:0]   i_seg_enb,
    input  logic                 i_seg_dp,
    input  logic [SEG_W-1:0]     i_seg,
    output logic [NUM_DIG*4-1:0] o_digits,
    output logic [NUM_DIG-1:0]   o_dp,
    output logic [NUM_DIG-1:0]   o_err,
    output logic                 o_frame_vld,
    input  logic                 i_frame_rdy,
    output logic                 o_ovf,
    output logic                 o_timeout
);

    localparam int              TW        = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]      STAB_LAST = 8'(STABLE_CYC - 1);
    localparam int              SNAP_W    = NUM_DIG + SEG_W + 1;

    state_t                     state_q, state_d;
    logic [SNAP_W-1:0]          snap_q, snap_d;
    logic [7:0]                 stab_q, stab_d;
    logic [NUM_DIG-1:0]         seen_q, seen_d;
    logic [TW-1:0]              tmo_cnt_q, tmo_cnt_d;
    logic [NUM_DIG-1:0][3:0]    dig_buf_q, dig_buf_d;
    logic [NUM_DIG-1:0]         dp_buf_q, dp_buf_d;
    logic [NUM_DIG-1:0]         err_buf_q, err_buf_d;
    logic [NUM_DIG-1:0][3:0]    dig_out_q, dig_out_d;
    logic [NUM_DIG-1:0]         dp_out_q, dp_out_d;
    logic [NUM_DIG-1:0]         err_out_q, err_out_d;
    logic                       vld_q, vld_d;
    logic                       ovf_q, ovf_d;
    logic                       tmo_q, tmo_d;

    logic                       bus_vld, changed, capture, complete, tmo_fire;
    logic [2:0]                 pos;
    logic [3:0]                 dec_digit;
    logic                       dec_err;

    seg7_decode u_decode (
        .i_seg   (i_seg),
        .o_digit (dec_digit),
        .o_err   (dec_err)
    );

    assign snap_d  = {i_seg_enb, i_seg, i_seg_dp};
    assign changed = (snap_d != snap_q);
    assign bus_vld = ($countones(~i_seg_enb) == 1);

    always_comb begin
        pos = 3'd0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (!i_seg_enb[i]) pos = 3'(i);
        end
    end

    // stab counts consecutive identical samples; capture on the STABLE_CYC-th.
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        capture = 1'b0;
        if (!bus_vld || changed) begin
            state_d = ST_IDLE;
            stab_d  = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_SETTLE: begin
                    stab_d = (state_q == ST_IDLE) ? 8'd1 : stab_q + 8'd1;
                    if (stab_d == STAB_LAST) begin
                        capture = 1'b1;
                        state_d = ST_HELD;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
                ST_HELD: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dig_buf_d = dig_buf_q;
        dp_buf_d  = dp_buf_q;
        err_buf_d = err_buf_q;
        dig_out_d = dig_out_q;
        dp_out_d  = dp_out_q;
        err_out_d = err_out_q;
        vld_d     = vld_q;
        ovf_d     = ovf_q;
        tmo_fire  = (seen_q != '0) && (seen_q != '1) && (tmo_cnt_q == TMO_LAST);
        tmo_d     = tmo_fire;
        seen_d    = tmo_fire ? '0 : seen_q;

        if (capture) begin
            dig_buf_d[pos] = dec_digit;
            dp_buf_d[pos]  = i_seg_dp;
            err_buf_d[pos] = dec_err;
            seen_d[pos]    = 1'b1;
        end
        complete = capture && (seen_d == '1);

        if (vld_q && i_frame_rdy) vld_d = 1'b0;
        if (complete) begin
            seen_d = '0;
            // A pending unaccepted frame is kept; the new one is dropped.
            if (!vld_q || i_frame_rdy) begin
                dig_out_d = dig_buf_d;
                dp_out_d  = dp_buf_d;
                err_out_d = err_buf_d;
                vld_d     = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (tmo_fire || complete || seen_d == '0 || seen_q == '0) tmo_cnt_d = '0;
        else                                                      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            snap_q    <= '0;
            stab_q    <= '0;
            seen_q    <= '0;
            tmo_cnt_q <= '0;
            dig_buf_q <= '0;
            dp_buf_q  <= '0;
            err_buf_q <= '0;
            dig_out_q <= '0;
            dp_out_q  <= '0;
            err_out_q <= '0;
            vld_q     <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            stab_q    <= stab_d;
            seen_q    <= seen_d;
            tmo_cnt_q <= tmo_cnt_d;
            dig_buf_q <= dig_buf_d;
            dp_buf_q  <= dp_buf_d;
            err_buf_q <= err_buf_d;
            dig_out_q <= dig_out_d;
            dp_out_q  <= dp_out_d;
            err_out_q <= err_out_d;
            vld_q     <= vld_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
        end
    end

    assign o_digits    = dig_out_q;
    assign o_dp        = dp_out_q;
    assign o_err       = err_out_q;
    assign o_frame_vld = vld_q;
    assign o_ovf       = ovf_q;
    assign o_timeout   = tmo_q;

endmodule

// File: tb/tb_seg_disp_capture.sv
// Self-checking bench for seg_disp_capture: scanned bus stimulus, frame scoreboard.
module tb_seg_disp_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  i_seg_enb;
    logic        i_seg_dp;
    logic [6:0]  i_seg;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic [5:0]  o_err;
    logic        o_frame_vld;
    logic        i_frame_rdy;
    logic        o_ovf;
    logic        o_timeout;

    seg_disp_capture #(.STABLE_CYC(4), .TIMEOUT_CYC(100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_seg_enb   (i_seg_enb),
        .i_seg_dp    (i_seg_dp),
        .i_seg       (i_seg),
        .o_digits    (o_digits),
        .o_dp        (o_dp),
        .o_err       (o_err),
        .o_frame_vld (o_frame_vld),
        .i_frame_rdy (i_frame_rdy),
        .o_ovf       (o_ovf),
        .o_timeout   (o_timeout)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [23:0] digs;
        logic [5:0]  dp;
        logic [5:0]  err;
    } frame_t;

    typedef struct {
        logic [23:0] digs;
        logic [5:0]  dp;
        logic [5:0]  blank;
        logic [23:0] exp_digs;
        logic [5:0]  exp_dp;
        logic [5:0]  exp_err;
    } vec_t;

    logic [6:0] hex_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    frame_t exp_q[$];
    frame_t mon_e;
    vec_t   vecs[4];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     tmo_cnt = 0;
    int     tmo_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every accepted frame must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_timeout) begin
                tmo_cnt++;
                tmo_cyc = cyc;
            end
            if (o_frame_vld && i_frame_rdy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got %h want none", o_digits);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("frame_digits", 32'(o_digits), 32'(mon_e.digs));
                    chk("frame_dp", 32'(o_dp), 32'(mon_e.dp));
                    chk("frame_err", 32'(o_err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic slot(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int n);
        i_seg_enb = enb;
        i_seg     = seg;
        i_seg_dp  = dp;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        slot(6'h3F, 7'h00, 1'b0, n);
    endtask

    task automatic scan(input logic [23:0] digs, input logic [5:0] dpm, input logic [5:0] blank,
                        input int first, input int last, input int n);
        logic [5:0] e;
        logic [5:0] one;
        one = 6'b000001;
        for (int p = first; p >= last; p--) begin
            e = ~(one << p);
            slot(e, blank[p] ? 7'h00 : hex_tbl[digs[p*4 +: 4]], dpm[p], n);
        end
    endtask

    task automatic push(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] err);
        frame_t f;
        f.digs = d;
        f.dp   = dp;
        f.err  = err;
        exp_q.push_back(f);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d frames pending want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int s;
        int t0;
        vecs[0] = '{24'h123456, 6'b000000, 6'b000000, 24'h123456, 6'b000000, 6'b000000};
        vecs[1] = '{24'h789ABC, 6'b101010, 6'b000000, 24'h789ABC, 6'b101010, 6'b000000};
        vecs[2] = '{24'hDEF312, 6'b000100, 6'b000100, 24'hDEF012, 6'b000100, 6'b000100};
        vecs[3] = '{24'h0F4B8E, 6'b100001, 6'b010000, 24'h004B8E, 6'b100001, 6'b010000};

        i_seg_enb   = 6'h3F;
        i_seg       = 7'h00;
        i_seg_dp    = 1'b0;
        i_frame_rdy = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", 32'(o_digits), 32'h0);
        chk("rst_dp", 32'(o_dp), 32'h0);
        chk("rst_err", 32'(o_err), 32'h0);
        chk("rst_vld", 32'(o_frame_vld), 32'h0);
        chk("rst_ovf", 32'(o_ovf), 32'h0);
        chk("rst_timeout", 32'(o_timeout), 32'h0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 4; i++) begin
            push(vecs[i].exp_digs, vecs[i].exp_dp, vecs[i].exp_err);
            scan(vecs[i].digs, vecs[i].dp, vecs[i].blank, 5, 0, 8);
            idle(2);
            drain("table_frame");
        end
        chk("table_no_timeout", 32'(tmo_cnt), 32'd0);

        // 3-cycle slot is one sample short of capture; a 4-cycle slot is enough.
        scan(24'h123456, 6'b0, 6'b0, 5, 1, 8);
        slot(6'b111110, hex_tbl[6], 1'b0, 3);
        idle(10);
        chk("short_slot_no_vld", 32'(o_frame_vld), 32'h0);
        push(24'h123456, 6'b0, 6'b0);
        slot(6'b111110, hex_tbl[6], 1'b0, 4);
        idle(3);
        drain("four_cycle_slot");

        // Two enables low must neither capture nor disturb the partial frame.
        scan(24'h654321, 6'b0, 6'b0, 5, 1, 8);
        slot(6'b001111, hex_tbl[8], 1'b1, 10);
        chk("two_low_no_vld", 32'(o_frame_vld), 32'h0);
        push(24'h654321, 6'b0, 6'b0);
        scan(24'h654321, 6'b0, 6'b0, 0, 0, 8);
        idle(2);
        drain("two_low_frame");

        // Second frame completes while first is unaccepted.
        i_frame_rdy = 1'b0;
        push(24'hA1B2C3, 6'b0, 6'b0);
        scan(24'hA1B2C3, 6'b0, 6'b0, 5, 0, 8);
        scan(24'h0F0F0F, 6'b111111, 6'b0, 5, 0, 8);
        idle(2);
        chk("ovf_set", 32'(o_ovf), 32'h1);
        chk("ovf_vld_held", 32'(o_frame_vld), 32'h1);
        chk("ovf_digits_held", 32'(o_digits), 32'hA1B2C3);
        chk("ovf_dp_held", 32'(o_dp), 32'h0);
        i_frame_rdy = 1'b1;
        idle(2);
        drain("ovf_first_frame");
        chk("ovf_vld_drop", 32'(o_frame_vld), 32'h0);
        chk("ovf_sticky", 32'(o_ovf), 32'h1);

        // Partial frame 5..1 then idle: one timeout pulse 100 cycles after first capture.
        t0 = tmo_cnt;
        s  = cyc;
        scan(24'hEDCBA9, 6'b0, 6'b0, 5, 1, 8);
        idle(110);
        chk("tmo_pulses", 32'(tmo_cnt - t0), 32'd1);
        chk("tmo_cycle", 32'(tmo_cyc - s), 32'd104);
        chk("tmo_digits_kept", 32'(o_digits), 32'hA1B2C3);
        chk("tmo_no_vld", 32'(o_frame_vld), 32'h0);
        push(24'h2468AC, 6'b0, 6'b0);
        scan(24'h2468AC, 6'b0, 6'b0, 5, 0, 8);
        idle(2);
        drain("after_tmo_frame");

        // Reset with a pending frame and a partial frame in progress.
        i_frame_rdy = 1'b0;
        scan(24'h111111, 6'b0, 6'b0, 5, 0, 8);
        scan(24'h222222, 6'b0, 6'b0, 5, 3, 8);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_vld", 32'(o_frame_vld), 32'h0);
        chk("midrst_ovf", 32'(o_ovf), 32'h0);
        chk("midrst_digits", 32'(o_digits), 32'h0);
        rst_n = 1'b1;
        i_frame_rdy = 1'b1;
        idle(2);
        scan(24'h333333, 6'b0, 6'b0, 2, 0, 8);
        idle(5);
        chk("midrst_partial_lost", 32'(o_frame_vld), 32'h0);
        push(24'h345333, 6'b0, 6'b0);
        scan(24'h345678, 6'b0, 6'b0, 5, 3, 8);
        idle(2);
        drain("midrst_frame");

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
